// File: rtl/cheri_dmem_responder.sv
// Data-side memory responder for the CHERIoT core: word SRAM with tag array,
// fixed response wait states and out-of-range error responses.
module cheri_dmem_responder #(
    parameter logic [31:0] AddrBase   = 32'h2000_0000,
    parameter int unsigned DepthWords = 1024,
    parameter int unsigned WaitStates = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [32:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic [32:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,
    input  logic        gnt_stall_i
);

    localparam int AW = $clog2(DepthWords);
    localparam logic [2:0] WS_M1 =
        3'((WaitStates == 0) ? 0 : WaitStates - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_nxt;

    logic [31:0]           r_mem [DepthWords];
    logic [DepthWords-1:0] r_tag;
    logic [32:0]           r_rdata;
    logic                  r_err;

    logic [31:0]   w_diff;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_gnt;
    logic          w_wr;
    logic          w_unused;

    assign w_diff = data_addr_i - AddrBase;
    // Compare the full word offset so addresses past the top never alias.
    assign w_in_range = (data_addr_i >= AddrBase) &&
                        ({2'b00, w_diff[31:2]} < 32'(DepthWords));
    assign w_idx = w_diff[AW+1:2];

    assign w_gnt = rstn_i & data_req_i & ~gnt_stall_i & (r_state != WAIT);
    assign w_wr  = w_gnt & data_we_i & w_in_range;

    assign data_gnt_o        = w_gnt;
    assign data_rvalid_o     = (r_state == RESP);
    assign data_rdata_o      = r_rdata;
    assign data_err_o        = r_err;
    assign data_rdata_intg_o = 7'h00;
    assign w_unused          = ^{data_wdata_intg_i, w_diff[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        unique case (r_state)
            IDLE, RESP: begin
                if (w_gnt) begin
                    if (WaitStates == 0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_wait_nxt  = WS_M1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_wait_nxt = r_wait_cnt - 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Data array is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Any partial write invalidates the capability tag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tag <= '0;
        end else if (w_wr) begin
            r_tag[w_idx] <= (data_be_i == 4'hF) & data_wdata_i[32];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdata <= 33'h0;
            r_err   <= 1'b0;
        end else if (w_gnt) begin
            if (!w_in_range) begin
                r_rdata <= 33'h0;
                r_err   <= 1'b1;
            end else if (data_we_i) begin
                r_rdata <= 33'h0;
                r_err   <= 1'b0;
            end else begin
                r_rdata <= {r_tag[w_idx], r_mem[w_idx]};
                r_err   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cheri_dmem_responder.md
# cheri_dmem_responder

Memory-side responder for the CHERIoT core data interface (req/gnt/rvalid protocol, 33-bit data with capability tag in bit 32). It is the slave end of the core's `data_*` port in DV and FPGA builds: a word-addressed SRAM model with a separately reset tag array, configurable response wait states, and address-range error signalling. It serves one request at a time and can pipeline back-to-back when `WaitStates` is 0.

## Interface
- `AddrBase`, 32'h2000_0000, byte address of word 0.
- `DepthWords`, 1024, number of 33-bit words; power of two, 16..65536.
- `WaitStates`, 0, extra cycles between grant and `data_rvalid_o`; 0..7.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `data_req_i`  in  1  request from core.
- `data_gnt_o`  out  1  request accepted this cycle.
- `data_rvalid_o`  out  1  response valid, one cycle per granted request.
- `data_we_i`  in  1  1 = write, 0 = read.
- `data_be_i`  in  4  byte enables.
- `data_addr_i`  in  32  byte address; bits [1:0] ignored.
- `data_wdata_i`  in  33  write data; bit 32 = tag.
- `data_wdata_intg_i`  in  7  ignored.
- `data_rdata_o`  out  33  read data; bit 32 = tag.
- `data_rdata_intg_o`  out  7  constant 7'h0.
- `data_err_o`  out  1  bus error, valid with `data_rvalid_o`.
- `gnt_stall_i`  in  1  DV stall injection; forces `data_gnt_o` low.

## Operation
- Word index = `(data_addr_i - AddrBase) >> 2`. In range iff `data_addr_i >= AddrBase` and index < `DepthWords` (33-bit compare, no wrap).
- `data_gnt_o = data_req_i & ~gnt_stall_i & (state==IDLE | state==RESP)`. Combinational; request fields are sampled on the grant edge.
- States: IDLE, WAIT, RESP.
  - IDLE: on grant -> RESP if `WaitStates`=0, else WAIT with `wait_cnt` loaded to `WaitStates`-1.
  - WAIT: decrement `wait_cnt`; at 0 -> RESP. No grant in WAIT.
  - RESP: `data_rvalid_o`=1 for exactly one cycle. If a new grant happens in this cycle, next state follows the IDLE rules; otherwise -> IDLE.
- Write (in range): committed on the grant edge. Data bytes are written where `data_be_i[i]`=1. Tag: if `data_be_i`==4'hF, tag := `data_wdata_i[32]`; otherwise tag := 0, because a partial write always clears the tag. The response has `data_rdata_o`=0 and `data_err_o`=0.
- Read (in range): the word and tag are captured into the response register on the grant edge. `data_be_i` is ignored and the full word is returned.
- Out of range: no memory or tag update. Response has `data_err_o`=1 and `data_rdata_o`=33'h0.
- Write followed by a read of the same word, granted one cycle later, returns the new data and tag.
- `data_err_o` and `data_rdata_o` are only meaningful when `data_rvalid_o`=1. They hold their last value otherwise.

## Timing
- Grant on edge T -> `data_rvalid_o` high in the cycle after edge T+`WaitStates`, i.e. latency 1+`WaitStates`.
- With `WaitStates`=0 and `req` held high, throughput is one transaction per cycle.
- With `WaitStates`=N>0, there is one transaction per N+1 cycles.
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE, `wait_cnt`=0.
  - `data_rvalid_o`=0, `data_err_o`=0, `data_rdata_o`=0.
  - All tag bits = 0. Data bits are not reset.
- A pending response is dropped on reset, with no rvalid afterwards.
- `data_gnt_o` is 0 during reset.
- `gnt_stall_i` never affects a response already granted.

## Test plan
- With `WaitStates`=0, write word 0x2000_0010 = 33'h1_DEAD_BEEF (be=F), then read the same address. Required: read rvalid 1 cycle after its grant, rdata=33'h1_DEAD_BEEF, err=0.
- Write 33'h1_1234_5678 be=F, then write 33'h0_0000_00AA be=4'b0001, then read. Required: rdata=33'h0_1234_56AA, showing the tag cleared by the partial write.
- Read address 0x1FFF_FFFC and read address AddrBase+4*DepthWords. Required: both give err=1, rdata=0, and the memory is unchanged.
- With `WaitStates`=3, issue 4 back-to-back reads with req held high. Required: grants 4 cycles apart, each rvalid 4 cycles after its grant, no gnt during WAIT.
- Hold `gnt_stall_i`=1 for 5 cycles with req high. Required: gnt=0 throughout. On release, gnt=1 the same cycle.
- Write tag=1 to word 5, then assert rstn_i low mid-WAIT of a later read. Required: rvalid never asserts for that read, all outputs 0 during reset, and a read of word 5 after reset returns tag=0.
